// File: rtl/gray_tracker_if.sv
// Signal bundle between a Gray-code counter and its downstream tracker:
// counter-side inputs in, decoded count and status out.
interface gray_tracker_if #(
  parameter int unsigned WRAP_W = 8
);
  logic [2:0]        Gray;
  logic              CntReset;
  logic              Clear;
  logic [2:0]        Bin;
  logic              Step;
  logic              Wrap;
  logic [WRAP_W-1:0] WrapCount;
  logic              Error;

  modport master (
    output Gray, CntReset, Clear,
    input  Bin, Step, Wrap, WrapCount, Error
  );

  modport slave (
    input  Gray, CntReset, Clear,
    output Bin, Step, Wrap, WrapCount, Error
  );
endinterface

// File: rtl/gray_tracker.sv
// Monitors a 3-bit Gray counter: decodes to binary, checks for legal +1 steps,
// counts 7->0 wraps (saturating) and raises a sticky error on illegal moves.
module gray_tracker #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic           Clk,
  input  logic           Reset,
  gray_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  localparam logic [WRAP_W-1:0] WC_ONE = WRAP_W'(1);

  state_t            state_q, state_d;
  logic [2:0]        prev_q,  prev_d;
  logic [2:0]        bin_q,   bin_d;
  logic              step_q,  step_d;
  logic              wrap_q,  wrap_d;
  logic [WRAP_W-1:0] wcnt_q,  wcnt_d;
  logic              err_q,   err_d;

  logic [2:0]        g_bin;
  logic [2:0]        p_bin;
  logic [2:0]        p_next;
  logic [WRAP_W-1:0] wbase;

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    gray2bin = {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    bin_d   = bin_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    wcnt_d  = wcnt_q;
    err_d   = err_q;

    g_bin  = gray2bin(bus.Gray);
    p_bin  = gray2bin(prev_q);
    p_next = p_bin + 3'd1;
    // Clear takes effect first, so a wrap in the same cycle counts from zero.
    wbase  = bus.Clear ? '0 : wcnt_q;

    unique case (state_q)
      S_INIT: begin
        prev_d  = bus.Gray;
        bin_d   = g_bin;
        wcnt_d  = wbase;
        err_d   = 1'b0;
        state_d = S_TRACK;
      end

      S_TRACK: begin
        wcnt_d = wbase;
        if (bus.Clear) begin
          err_d = 1'b0;
        end
        if (bus.CntReset) begin
          prev_d = '0;
          bin_d  = '0;
          if (bus.Gray != 3'b000) begin
            err_d   = 1'b1;
            state_d = S_ERROR;
          end
        end else if (bus.Gray == prev_q) begin
          // no change: hold
        end else if (g_bin == p_next) begin
          prev_d = bus.Gray;
          bin_d  = g_bin;
          step_d = 1'b1;
          if (p_bin == 3'd7) begin
            wrap_d = 1'b1;
            if (wbase != '1) begin
              wcnt_d = wbase + WC_ONE;
            end
          end
        end else begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end
      end

      S_ERROR: begin
        if (bus.Clear) begin
          wcnt_d = '0;
        end
        if (bus.Clear || bus.CntReset) begin
          err_d   = 1'b0;
          state_d = S_INIT;
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_INIT;
      prev_q  <= '0;
      bin_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      bin_q   <= bin_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.Bin       = bin_q;
  assign bus.Step      = step_q;
  assign bus.Wrap      = wrap_q;
  assign bus.WrapCount = wcnt_q;
  assign bus.Error     = err_q;

  a_err_not_step: assert property (@(posedge Clk) disable iff (!Reset) !(err_q && step_q));

endmodule

// File: tb/tb_gray_tracker.sv
// Directed bench for gray_tracker: two instances (WRAP_W=8 and WRAP_W=2) share
// the same stimulus; expected values are hand-derived from the Gray sequence.
module tb_gray_tracker;

  logic       Clk;
  logic       Reset;
  logic [2:0] gray;
  logic       cnt_reset;
  logic       clear;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                           3'b110, 3'b111, 3'b101, 3'b100};

  gray_tracker_if #(.WRAP_W(8)) bus_a ();
  gray_tracker_if #(.WRAP_W(2)) bus_b ();

  assign bus_a.Gray     = gray;
  assign bus_a.CntReset = cnt_reset;
  assign bus_a.Clear    = clear;
  assign bus_b.Gray     = gray;
  assign bus_b.CntReset = cnt_reset;
  assign bus_b.Clear    = clear;

  gray_tracker #(.WRAP_W(8)) u_dut_a (.Clk(Clk), .Reset(Reset), .bus(bus_a));
  gray_tracker #(.WRAP_W(2)) u_dut_b (.Clk(Clk), .Reset(Reset), .bus(bus_b));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [2:0] bin, input logic step,
                         input logic wrap, input logic err);
    check({tag, ".bin"},  32'(bus_a.Bin),   32'(bin));
    check({tag, ".step"}, 32'(bus_a.Step),  32'(step));
    check({tag, ".wrap"}, 32'(bus_a.Wrap),  32'(wrap));
    check({tag, ".err"},  32'(bus_a.Error), 32'(err));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    Reset     = 1'b0;
    gray      = 3'b000;
    cnt_reset = 1'b0;
    clear     = 1'b0;

    #3;
    check_a("rst", 3'd0, 1'b0, 1'b0, 1'b0);
    check("rst.wc", 32'(bus_a.WrapCount), 32'd0);
    #9 Reset = 1'b1;

    // INIT capture followed by two idle cycles on 000
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a($sformatf("idle%0d", i), 3'd0, 1'b0, 1'b0, 1'b0);
    end

    // five full laps of the legal sequence
    for (int k = 1; k <= 40; k++) begin
      gray = gseq[k % 8];
      tick();
      check_a($sformatf("lap%0d", k), 3'(k % 8), 1'b1, (k % 8) == 0, 1'b0);
      check($sformatf("lap%0d.wrapb", k), 32'(bus_b.Wrap), 32'((k % 8) == 0));
      if (k == 16) begin
        check("wc_after2.a", 32'(bus_a.WrapCount), 32'd2);
        check("wc_after2.b", 32'(bus_b.WrapCount), 32'd2);
      end
    end
    check("wc_after5.a", 32'(bus_a.WrapCount), 32'd5);
    check("wc_sat.b",    32'(bus_b.WrapCount), 32'd3);

    // illegal jump 010 -> 111
    for (int k = 1; k <= 3; k++) begin
      gray = gseq[k];
      tick();
    end
    check_a("to3", 3'd3, 1'b1, 1'b0, 1'b0);
    gray = 3'b111;
    tick();
    check_a("illegal", 3'd3, 1'b0, 1'b0, 1'b1);
    gray = 3'b110;
    tick();
    check_a("err_ignore", 3'd3, 1'b0, 1'b0, 1'b1);
    clear = 1'b1;
    tick();
    check_a("clear", 3'd3, 1'b0, 1'b0, 1'b0);
    check("clear.wc.a", 32'(bus_a.WrapCount), 32'd0);
    check("clear.wc.b", 32'(bus_b.WrapCount), 32'd0);
    clear = 1'b0;
    tick();
    check_a("recapture", 3'd4, 1'b0, 1'b0, 1'b0);

    // CntReset-qualified jump 111 -> 000
    gray = 3'b111;
    tick();
    check_a("to5", 3'd5, 1'b1, 1'b0, 1'b0);
    gray      = 3'b000;
    cnt_reset = 1'b1;
    tick();
    check_a("cntreset", 3'd0, 1'b0, 1'b0, 1'b0);
    check("cntreset.wc", 32'(bus_a.WrapCount), 32'd0);
    cnt_reset = 1'b0;
    tick();
    check_a("hold0", 3'd0, 1'b0, 1'b0, 1'b0);

    // same jump without CntReset is illegal
    for (int k = 1; k <= 5; k++) begin
      gray = gseq[k];
      tick();
    end
    check_a("to5b", 3'd5, 1'b1, 1'b0, 1'b0);
    gray = 3'b000;
    tick();
    check_a("jump_noreset", 3'd5, 1'b0, 1'b0, 1'b1);

    // CntReset leaves ERROR through INIT
    cnt_reset = 1'b1;
    tick();
    check_a("err_exit", 3'd5, 1'b0, 1'b0, 1'b0);
    cnt_reset = 1'b0;
    tick();
    check_a("recapture0", 3'd0, 1'b0, 1'b0, 1'b0);

    for (int k = 1; k <= 16; k++) begin
      gray = gseq[k % 8];
      tick();
    end
    check("wc2.a", 32'(bus_a.WrapCount), 32'd2);
    gray = 3'b011;
    tick();
    check_a("err_before_rst", 3'd0, 1'b0, 1'b0, 1'b1);
    check("wc_before_rst", 32'(bus_a.WrapCount), 32'd2);

    // asynchronous reset between edges
    #2 Reset = 1'b0;
    #1;
    check_a("async_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    check("async_rst.wc.a", 32'(bus_a.WrapCount), 32'd0);
    check("async_rst.wc.b", 32'(bus_b.WrapCount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_tracker.md
# gray_tracker

Downstream monitor for the 3-bit Gray-code counter. Samples the counter's Gray output every clock and decodes it to binary. Checks that every change is a legal +1 Gray step, counts 7→0 wrap-arounds and flags any illegal transition with a sticky error. It feeds status and the binary count to the display/check logic that follows the counter.

## Interface
Parameters:
- WRAP_W, 8, width of the wrap counter; saturates at 2^WRAP_W−1.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- Gray  input  3  Gray code from the counter's Output.
- CntReset  input  1  copy of the counter's synchronous Reset; marks a legal jump to 000.
- Clear  input  1  synchronous, active-high; leaves ERROR and clears Error/WrapCount.
- Bin  output  3  registered binary value of the last accepted Gray sample.
- Step  output  1  one-cycle pulse when a legal +1 step is accepted.
- Wrap  output  1  one-cycle pulse when the accepted step is 7→0 (binary).
- WrapCount  output  WRAP_W  saturating count of accepted wraps.
- Error  output  1  sticky illegal-transition flag.

## Operation
- Decode: b2=g2; b1=g2^g1; b0=g2^g1^g0. Legal sequence is 000,001,011,010,110,111,101,100, then back to 000.
- Internal register Prev[2:0] holds the last accepted Gray sample.
- FSM states: INIT, TRACK, ERROR. Reset (Reset=0) forces the following:
  - state INIT, Prev=000, Bin=0, Step=0, Wrap=0, WrapCount=0, Error=0.
- INIT: on the next edge Prev←Gray, Bin←decode(Gray), go to TRACK. No Step, no Wrap.
- TRACK: for each edge, evaluate in this priority order.
  - Clear=1: WrapCount←0 and Error←0. Gray is then evaluated normally in the same cycle.
  - CntReset=1: Gray must be 000.
    - Prev←000, Bin←0, no Step, no Wrap, no WrapCount change.
    - If Gray≠000, Error←1 and go to ERROR.
  - Gray==Prev: hold. Step=0, Wrap=0.
  - decode(Gray)==decode(Prev)+1 mod 8:
    - Prev←Gray, Bin←decode(Gray), Step←1.
    - If decode(Prev)==7: Wrap←1 and WrapCount←WrapCount+1, saturating.
  - Any other value (multi-bit change, backward step, skip): Error←1, go to ERROR. Prev and Bin hold.
- ERROR:
  - Error stays 1. Bin holds the last good value. Step=0, Wrap=0. Gray is ignored.
  - Clear=1 or CntReset=1: Error←0, go to INIT.
  - WrapCount is cleared only on Clear.
- Arithmetic: binary +1 is mod 8. WrapCount never wraps; it sticks at its maximum.

## Timing
- All outputs are registered. A Gray change sampled at edge N shows on Bin/Step/Wrap after edge N, and is visible during cycle N+1.
- Step and Wrap are single-cycle pulses. Back-to-back legal steps on consecutive edges give consecutive Step pulses.
- A counter with En=1 changes Gray every cycle. The block must accept one step per cycle with no bubbles.
- Reset is asynchronous. Deassertion takes effect at the next Clk edge, which is the INIT capture edge.
- Reset asserted mid-step: outputs clear immediately, and any pending Step/Wrap is lost.
- Clear and CntReset are simultaneous in TRACK: Clear's action applies first, then CntReset's resync rule.
- Error and Step are never both 1 in the same cycle.

## Test plan
- Reset, then Gray held 000 for 3 cycles → Bin=0, Step=0, Error=0, state TRACK after 1 edge.
- Drive the legal sequence 000→001→…→100→000 twice, one code per cycle → Step high every cycle after INIT, Bin follows 0..7, Wrap pulses twice, WrapCount=2.
- From Bin=3 (Gray 010), drive Gray=111 → Error=1 next cycle, Bin stays 3, later legal codes give no Step. Then Clear=1 → Error=0, WrapCount=0, INIT, recapture.
- From Bin=5 (Gray 111), drive Gray=000 with CntReset=1 → Bin=0, no Step, no Wrap, Error=0. Same jump with CntReset=0 → Error=1.
- Set WRAP_W=2 and drive 5 full cycles → WrapCount saturates at 3, Wrap still pulses each time.
- Assert Reset=0 asynchronously between edges while Error=1 and WrapCount=2 → all outputs 0 immediately, before the next Clk edge.
